mul_booth_seq: RTL



---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_booth_seq_if.sv | 23 ++
 rtl/booth_digit.sv | 23 ++
 rtl/mul_booth_seq.sv | 89 ++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// RV32M multiply op codes, sequencer states and the Booth group count.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 33-bit extended multiplier padded to 34 bits gives 17 radix-4 groups
  localparam int unsigned BOOTH_ITERS = 17;

endpackage

// File: rtl/mul_booth_seq_if.sv
// Request/response bundle between the execute stage and the Booth multiplier.
interface mul_booth_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic [31:0] out_word;
  logic        busy;

  modport master (
    output in_valid, in_op, in_op1, in_op2, out_ready,
    input  in_ready, out_valid, out_res, out_word, busy
  );

  modport slave (
    input  in_valid, in_op, in_op1, in_op2, out_ready,
    output in_ready, out_valid, out_res, out_word, busy
  );
endinterface

// File: rtl/booth_digit.sv
// Radix-4 Booth recoder: maps one 3-bit multiplier group to the 64-bit
// partial-product term 0, +mc, +2mc, -mc or -2mc (two's complement).
module booth_digit (
  input  logic [2:0]  grp,
  input  logic [63:0] mc,
  output logic [63:0] term
);

  logic [63:0] mc2;

  always_comb begin
    mc2  = {mc[62:0], 1'b0};
    term = '0;
    case (grp)
      3'b001, 3'b010: term = mc;
      3'b011:         term = mc2;
      3'b100:         term = ~mc2 + 64'd1;
      3'b101, 3'b110: term = ~mc + 64'd1;
      default:        term = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth group per cycle into a
// 64-bit accumulator, returning the full product and the RV32M result word.
module mul_booth_seq
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mul_booth_seq_if.slave  bus
);

  localparam logic [4:0] LAST_CNT = 5'(BOOTH_ITERS - 1);

  state_t             state, state_nxt;
  mul_op_t            op;
  logic        [4:0]  cnt;
  logic signed [34:0] mr;
  logic        [63:0] mc;
  logic        [63:0] acc;
  logic        [63:0] term;
  logic               accept;
  logic               s1, s2;
  logic        [32:0] op1x;
  logic        [33:0] op2x;

  // Operand extension: signedness of each operand depends on the op code
  always_comb begin
    s1   = (bus.in_op != MUL_OP_MULHU);
    s2   = (bus.in_op == MUL_OP_MUL) || (bus.in_op == MUL_OP_MULH);
    op1x = {s1 & bus.in_op1[31], bus.in_op1};
    op2x = {{2{s2 & bus.in_op2[31]}}, bus.in_op2};
  end

  assign accept = bus.in_valid && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid)      state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == LAST_CNT)   state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)     state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  booth_digit u_digit (
    .grp  (mr[2:0]),
    .mc   (mc),
    .term (term)
  );

  // Accumulator, iteration counter and latched op are cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      op  <= MUL_OP_MUL;
    end else if (accept) begin
      acc <= '0;
      cnt <= '0;
      op  <= mul_op_t'(bus.in_op);
    end else if (state == ST_BUSY) begin
      acc <= acc + term;
      cnt <= cnt + 5'd1;
    end
  end

  // Shift registers carry no reset: they are reloaded on every accept
  always_ff @(posedge clk) begin
    if (accept) begin
      mr <= {op2x, 1'b0};
      mc <= {{31{op1x[32]}}, op1x};
    end else if (state == ST_BUSY) begin
      mr <= mr >>> 2;
      mc <= {mc[61:0], 2'b00};
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_BUSY);
  assign bus.out_res   = acc;
  assign bus.out_word  = (op == MUL_OP_MUL) ? acc[31:0] : acc[63:32];

endmodule
